clock_ctrl: RTL

CLOCK_CTRL -- requirements
Module: clock_ctrl

---
 rtl/clock_ctrl_pkg.sv | 12 +
 rtl/clk_en_counter.sv | 42 ++++
 rtl/clock_ctrl.sv | 98 +++++++++
 3 files changed

// File: rtl/clock_ctrl_pkg.sv
// Shared definitions for the clock-enable controller: FSM state encoding and default widths.
package clock_ctrl_pkg;

    localparam int unsigned CntWDefault = 4;

    typedef enum logic [1:0] {
        StHalt = 2'd0,
        StRun  = 2'd1,
        StStep = 2'd2
    } state_e;

endpackage

// File: rtl/clk_en_counter.sv
// Period counter: counts 0..div_cur while enabled, flags the boundary cycle and
// registers a one-cycle clk_en pulse in the cycle after each boundary.
module clk_en_counter
    import clock_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = CntWDefault
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             count_en,
    input  logic [CNT_W-1:0] div_cur,
    output logic             boundary,
    output logic             clk_en
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clk_en_q;

    assign boundary = count_en && (cnt_q == div_cur);
    assign clk_en   = clk_en_q;

    // Counter rests at 0 whenever disabled, so every new period starts clean.
    always_comb begin
        cnt_d = cnt_q;
        if (!count_en || boundary) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            clk_en_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            clk_en_q <= boundary;
        end
    end

endmodule

// File: rtl/clock_ctrl.sv
// Clock-enable controller: HALT/RUN/STEP sequencing plus a glitch-free divide-ratio
// change handshake that only switches ratio on period boundaries.
module clock_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W     = CntWDefault,
    parameter int unsigned DIV_RESET = 3
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             run,
    input  logic             step,
    input  logic [CNT_W-1:0] div_sel,
    input  logic             div_req,
    output logic             div_ack,
    output logic             clk_en,
    output logic             busy,
    output logic [CNT_W-1:0] div_cur
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] div_cur_q, div_cur_d;
    logic [CNT_W-1:0] pend_sel_q, pend_sel_d;
    logic             pend_q, pend_d;
    logic             apply_q, apply;
    logic             div_ack_q;
    logic             count_en;
    logic             boundary;

    assign count_en = (state_q != StHalt);
    assign busy     = count_en;
    assign div_cur  = div_cur_q;
    assign div_ack  = div_ack_q;

    clk_en_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .count_en (count_en),
        .div_cur  (div_cur_q),
        .boundary (boundary),
        .clk_en   (clk_en)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StHalt: begin
                if (run) begin
                    state_d = StRun;
                end else if (step) begin
                    state_d = StStep;
                end
            end
            StRun:   if (boundary && !run) state_d = StHalt;
            StStep:  if (boundary) state_d = StHalt;
            default: state_d = StHalt;
        endcase
    end

    // apply_q blocks a second application while the ack is still in flight.
    assign apply = pend_q && !apply_q && ((state_q == StHalt) || boundary);

    always_comb begin
        pend_d     = pend_q;
        pend_sel_d = pend_sel_q;
        div_cur_d  = div_cur_q;
        if (apply_q) begin
            pend_d = 1'b0;
        end else if (div_req && !pend_q) begin
            pend_d     = 1'b1;
            pend_sel_d = div_sel;
        end
        if (apply) begin
            div_cur_d = pend_sel_q;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StHalt;
            div_cur_q  <= CNT_W'(DIV_RESET);
            pend_sel_q <= '0;
            pend_q     <= 1'b0;
            apply_q    <= 1'b0;
            div_ack_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_cur_q  <= div_cur_d;
            pend_sel_q <= pend_sel_d;
            pend_q     <= pend_d;
            apply_q    <= apply;
            div_ack_q  <= apply_q;
        end
    end

endmodule
